// File: rtl/calcu_pkg.sv
// Shared definitions for the 4-bit calculator front end.
// Contents:
//   estado_t   capture FSM states; the encoding is shown on the board LEDs.
//   NUM_OPS    number of valid operation codes (0..NUM_OPS-1).
//   OP_*       operation codes understood by the calculator.
package calcu_pkg;

    localparam int NUM_OPS = 10;

    localparam logic [3:0] OP_SUM    = 4'd0;
    localparam logic [3:0] OP_REST   = 4'd1;
    localparam logic [3:0] OP_MOD    = 4'd2;
    localparam logic [3:0] OP_MULT   = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_AND    = 4'd5;
    localparam logic [3:0] OP_OR     = 4'd6;
    localparam logic [3:0] OP_XOR    = 4'd7;
    localparam logic [3:0] OP_LSHIFT = 4'd8;
    localparam logic [3:0] OP_RSHIFT = 4'd9;

    typedef enum logic [2:0] {
        ESPERA_A   = 3'd0,
        ESPERA_B   = 3'd1,
        ESPERA_OP  = 3'd2,
        CALCULA    = 3'd3,
        CAPTURA    = 3'd4,
        MUESTRA    = 3'd5
    } estado_t;

endpackage

// File: rtl/sincroniza_pulso.sv
// Synchroniser plus rising-edge detector for an asynchronous, already
// debounced push-button level.  Produces a registered one-cycle pulse
// SYNC_STAGES+1 cycles after the input rises.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   din         asynchronous button level
//   pulso       one-cycle pulse on each rising edge of din
module sincroniza_pulso #(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulso
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            prev  <= 1'b0;
            pulso <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], din};
            prev  <= sync[SYNC_STAGES-1];
            pulso <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/captura_operaciones.sv
// Sequential front end for the combinational 4-bit calculator.  Captures
// operand A, operand B and the opcode from the switches, one "enter" press
// per item, presents them to the calculator, and registers the returned
// result and flags for display until the next operation starts.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   dato_in, sel_in         operand / opcode switches
//   boton, cancelar         enter / abort buttons (async, debounced levels)
//   a_out, b_out,
//   seleccion_out           operands and opcode driven to the calculator
//   salida_in, flags_in     calculator result and flags
//   resultado, flags        registered result and flags
//   valido                  resultado/flags hold a fresh result
//   error_op                sticky rejected-opcode indicator
//   estado                  FSM state for LEDs
//   num_ops                 completed-operation counter (wraps)
module captura_operaciones
    import calcu_pkg::*;
#(
    parameter int N           = 4,
    parameter int NUM_OPS     = calcu_pkg::NUM_OPS,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] dato_in,
    input  logic [3:0]   sel_in,
    input  logic         boton,
    input  logic         cancelar,
    output logic [N-1:0] a_out,
    output logic [N-1:0] b_out,
    output logic [3:0]   seleccion_out,
    input  logic [N-1:0] salida_in,
    input  logic [3:0]   flags_in,
    output logic [N-1:0] resultado,
    output logic [3:0]   flags,
    output logic         valido,
    output logic         error_op,
    output logic [2:0]   estado,
    output logic [7:0]   num_ops
);

    logic    pulso_ok;
    logic    pulso_cancel;
    estado_t st;

    sincroniza_pulso #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ok (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (boton),
        .pulso (pulso_ok)
    );

    sincroniza_pulso #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cancel (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cancelar),
        .pulso (pulso_cancel)
    );

    assign estado = st;

    // Cancel is honoured everywhere except while an operation is in flight,
    // so a started calculation always completes and is counted.
    logic cancel_ok;
    assign cancel_ok = pulso_cancel && (st != CALCULA) && (st != CAPTURA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st            <= ESPERA_A;
            a_out         <= '0;
            b_out         <= '0;
            seleccion_out <= '0;
            resultado     <= '0;
            flags         <= '0;
            valido        <= 1'b0;
            error_op      <= 1'b0;
            num_ops       <= '0;
        end else if (cancel_ok) begin
            // Result registers and counter deliberately survive a cancel.
            st            <= ESPERA_A;
            a_out         <= '0;
            b_out         <= '0;
            seleccion_out <= '0;
            error_op      <= 1'b0;
        end else begin
            case (st)
                ESPERA_A: if (pulso_ok) begin
                    a_out    <= dato_in;
                    error_op <= 1'b0;
                    st       <= ESPERA_B;
                end
                ESPERA_B: if (pulso_ok) begin
                    b_out <= dato_in;
                    st    <= ESPERA_OP;
                end
                ESPERA_OP: if (pulso_ok) begin
                    if (32'(sel_in) < NUM_OPS) begin
                        seleccion_out <= sel_in;
                        st            <= CALCULA;
                    end else begin
                        error_op <= 1'b1;
                    end
                end
                CALCULA: begin
                    // Operands have been stable for a full cycle, so the
                    // calculator output is settled: sample it on the edge
                    // that enters CAPTURA, two cycles after the opcode pulse.
                    resultado <= salida_in;
                    flags     <= flags_in;
                    valido    <= 1'b1;
                    num_ops   <= num_ops + 8'd1;
                    st        <= CAPTURA;
                end
                CAPTURA: st <= MUESTRA;
                MUESTRA: if (pulso_ok) begin
                    // The press starts the next operation with its operand A.
                    valido <= 1'b0;
                    a_out  <= dato_in;
                    st     <= ESPERA_B;
                end
                default: st <= ESPERA_A;
            endcase
        end
    end

endmodule

// File: tb/tb_captura_operaciones.sv
// Directed bench for captura_operaciones with a small calculator model in
// the loop.  Expected values are hand-computed constants.
module tb_captura_operaciones;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dato_in, sel_in;
    logic       boton, cancelar;
    logic [3:0] a_out, b_out, seleccion_out;
    logic [3:0] salida_in, flags_in;
    logic [3:0] resultado, flags;
    logic       valido, error_op;
    logic [2:0] estado;
    logic [7:0] num_ops;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    captura_operaciones #(.N(4), .NUM_OPS(10), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dato_in       (dato_in),
        .sel_in        (sel_in),
        .boton         (boton),
        .cancelar      (cancelar),
        .a_out         (a_out),
        .b_out         (b_out),
        .seleccion_out (seleccion_out),
        .salida_in     (salida_in),
        .flags_in      (flags_in),
        .resultado     (resultado),
        .flags         (flags),
        .valido        (valido),
        .error_op      (error_op),
        .estado        (estado),
        .num_ops       (num_ops)
    );

    // Calculator model: flags = {negative, zero, carry, overflow}.
    logic [4:0] t;
    logic       c, v;
    always_comb begin
        t = 5'd0;
        c = 1'b0;
        v = 1'b0;
        case (seleccion_out)
            4'd0: begin
                t = {1'b0, a_out} + {1'b0, b_out};
                c = t[4];
                v = (a_out[3] == b_out[3]) && (t[3] != a_out[3]);
            end
            4'd1: begin
                t = {1'b0, a_out} - {1'b0, b_out};
                c = t[4];
                v = (a_out[3] != b_out[3]) && (t[3] != a_out[3]);
            end
            4'd2: t = (b_out != 0) ? {1'b0, a_out % b_out} : 5'd0;
            4'd3: t = {1'b0, 4'(a_out * b_out)};
            4'd4: t = (b_out != 0) ? {1'b0, a_out / b_out} : 5'd0;
            4'd5: t = {1'b0, a_out & b_out};
            4'd6: t = {1'b0, a_out | b_out};
            4'd7: t = {1'b0, a_out ^ b_out};
            4'd8: t = {1'b0, a_out << b_out};
            4'd9: t = {1'b0, a_out >> b_out};
            default: t = 5'd0;
        endcase
        salida_in = t[3:0];
        flags_in  = {t[3], t[3:0] == 4'd0, c, v};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Raise the requested buttons and wait until the FSM has acted on the
    // pulse (sync 2 + registered pulse + FSM edge = 4 edges).
    task automatic pulse(input logic ok, input logic cn);
        @(posedge clk); #1;
        boton    = ok;
        cancelar = cn;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic release_btn();
        boton    = 1'b0;
        cancelar = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic ok, input logic cn);
        pulse(ok, cn);
        release_btn();
    endtask

    initial begin
        rst_n = 1'b0; dato_in = '0; sel_in = '0; boton = 1'b0; cancelar = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_estado", estado, 0);
        chk("rst_a", a_out, 0);
        chk("rst_res", resultado, 0);
        chk("rst_valido", valido, 0);
        chk("rst_ops", num_ops, 0);
        chk("rst_err", error_op, 0);
        rst_n = 1'b1;

        // Addition 3 + 5
        dato_in = 4'd3; press(1, 0);
        chk("add_a", a_out, 3);
        chk("add_st_b", estado, 1);
        dato_in = 4'd5; press(1, 0);
        chk("add_b", b_out, 5);
        chk("add_st_op", estado, 2);
        sel_in = 4'd0; pulse(1, 0);
        chk("add_st_calc", estado, 3);
        chk("add_sel", seleccion_out, 0);
        chk("add_valido_early", valido, 0);
        @(posedge clk); #1;
        chk("add_valido", valido, 1);
        chk("add_res", resultado, 8);
        chk("add_flags", flags, 4'b1001);
        chk("add_ops", num_ops, 1);
        chk("add_st_capt", estado, 4);
        release_btn();
        chk("add_st_show", estado, 5);

        // MUESTRA press loads next A, valido drops; then cancel in ESPERA_B
        dato_in = 4'd9; pulse(1, 0);
        chk("show_valido_drop", valido, 0);
        chk("show_a", a_out, 9);
        chk("show_st", estado, 1);
        chk("show_res_hold", resultado, 8);
        release_btn();
        press(0, 1);
        chk("cancel_st", estado, 0);
        chk("cancel_a", a_out, 0);
        chk("cancel_res", resultado, 8);
        chk("cancel_valido", valido, 0);
        chk("cancel_ops", num_ops, 1);

        // Invalid opcode then XOR 6 ^ 3
        dato_in = 4'd6; press(1, 0);
        dato_in = 4'd3; press(1, 0);
        sel_in = 4'd12; press(1, 0);
        chk("inv_err", error_op, 1);
        chk("inv_st", estado, 2);
        chk("inv_sel", seleccion_out, 0);
        sel_in = 4'd7; press(1, 0);
        chk("xor_st", estado, 5);
        chk("xor_res", resultado, 5);
        chk("xor_flags", flags, 0);
        chk("xor_sel", seleccion_out, 7);
        chk("xor_err_sticky", error_op, 1);
        chk("xor_ops", num_ops, 2);
        dato_in = 4'd1; press(1, 0);
        chk("show_err_sticky", error_op, 1);
        press(0, 1);
        chk("cancel_err", error_op, 0);
        chk("cancel_st2", estado, 0);

        // Simultaneous enter and cancel in ESPERA_OP
        dato_in = 4'd1; press(1, 0);
        dato_in = 4'd2; press(1, 0);
        sel_in = 4'd0; press(1, 1);
        chk("simul_st", estado, 0);
        chk("simul_ops", num_ops, 2);
        chk("simul_a", a_out, 0);

        // Chained operations up to counter wrap
        dato_in = 4'd1; sel_in = 4'd0;
        press(1, 0); press(1, 0); press(1, 0);
        chk("chain_res", resultado, 2);
        chk("chain_ops", num_ops, 3);
        for (int i = 0; i < 253; i++) begin
            press(1, 0); press(1, 0); press(1, 0);
        end
        chk("wrap_ops", num_ops, 0);
        chk("wrap_st", estado, 5);

        // Async reset during CALCULA (4 + 4 would give 8)
        dato_in = 4'd4; press(1, 0); press(1, 0);
        sel_in = 4'd0; pulse(1, 0);
        chk("mid_st_calc", estado, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_st", estado, 0);
        chk("mid_rst_res", resultado, 0);
        chk("mid_rst_a", a_out, 0);
        chk("mid_rst_b", b_out, 0);
        chk("mid_rst_valido", valido, 0);
        chk("mid_rst_flags", flags, 0);
        boton = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("post_rst_res", resultado, 0);
        chk("post_rst_ops", num_ops, 0);
        chk("post_rst_st", estado, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: got no end of test, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

endmodule
